// File: rtl/ps2_arrow_decoder_if.sv
// ps2_arrow_decoder_if
//   Groups the PS/2 line inputs and the decoded outputs of ps2_arrow_decoder.
//   The design side binds to the slave modport. The keyboard/consumer side
//   binds to the master modport.
//   Signals:
//     ps2_clk    raw PS/2 clock line (asynchronous to pclk)
//     ps2_data   raw PS/2 data line (asynchronous to pclk)
//     key        held-arrow mask {right, left, down, up}
//     byte_valid one-cycle pulse per accepted frame
//     rx_byte    last accepted byte
//     frame_err  one-cycle pulse on parity/stop/timeout error
interface ps2_arrow_decoder_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [3:0] key;
  logic       byte_valid;
  logic [7:0] rx_byte;
  logic       frame_err;

  modport master (
    output ps2_clk,
    output ps2_data,
    input  key,
    input  byte_valid,
    input  rx_byte,
    input  frame_err
  );

  modport slave (
    input  ps2_clk,
    input  ps2_data,
    output key,
    output byte_valid,
    output rx_byte,
    output frame_err
  );
endinterface

// File: rtl/ps2_arrow_decoder.sv
// ps2_arrow_decoder
//   Receives PS/2 keyboard frames and keeps a registered mask of the arrow
//   keys currently held (bit0 up, bit1 down, bit2 left, bit3 right).
//   Ports:
//     pclk  system clock, all logic on its rising edge
//     rst   synchronous active-high reset
//     bus   ps2_arrow_decoder_if.slave: ps2_clk/ps2_data in,
//           key/byte_valid/rx_byte/frame_err out (all outputs registered)
//   Parameters:
//     FILTER_LEN      equal synchronized samples needed to move the filtered clock
//     TIMEOUT_CYCLES  pclk cycles without a falling edge before a frame is aborted
module ps2_arrow_decoder #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 65000
) (
  input logic                pclk,
  input logic                rst,
  ps2_arrow_decoder_if.slave bus
);

  localparam int FILT_W = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN + 1);
  localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(FILTER_LEN - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0] CODE_EXT = 8'hE0;
  localparam logic [7:0] CODE_BRK = 8'hF0;

  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {SC_IDLE, SC_EXT, SC_BRK, SC_EXT_BRK} sc_state_t;

  // Odd parity holds when data plus parity bit contain an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

  // Mask bit for an extended arrow code, zero for anything else.
  function automatic logic [3:0] arrow_mask(input logic [7:0] code);
    logic [3:0] m;
    case (code)
      8'h75:   m = 4'b0001;
      8'h72:   m = 4'b0010;
      8'h6B:   m = 4'b0100;
      8'h74:   m = 4'b1000;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  // BAT pass/fail and overrun codes wipe the key state from any prefix state.
  function automatic logic is_clear_code(input logic [7:0] code);
    logic c;
    case (code)
      8'hAA, 8'hFC, 8'h00, 8'hFF: c = 1'b1;
      default:                    c = 1'b0;
    endcase
    return c;
  endfunction

  logic [1:0]        clk_sync_r;
  logic [1:0]        data_sync_r;
  logic              clk_filt_r;
  logic [FILT_W-1:0] filt_cnt_r;
  logic [FILT_W-1:0] filt_cnt_next_s;
  logic              filt_flip_s;
  logic              fall_r;
  logic              data_s;

  rx_state_t         rx_state_r;
  rx_state_t         rx_next_s;
  logic [2:0]        bit_cnt_r;
  logic [2:0]        bit_cnt_next_s;
  logic [7:0]        shift_r;
  logic [7:0]        shift_next_s;
  logic              par_r;
  logic              par_next_s;
  logic [TMO_W-1:0]  tmo_cnt_r;
  logic [TMO_W-1:0]  tmo_next_s;
  logic              accept_s;
  logic              err_s;

  sc_state_t         sc_state_r;
  sc_state_t         sc_next_s;
  logic [3:0]        key_r;
  logic [3:0]        key_next_s;
  logic              byte_valid_r;
  logic              frame_err_r;
  logic [7:0]        rx_byte_r;

  assign data_s = data_sync_r[1];

  // Two-flop synchronizers for both raw PS/2 lines; idle level is high.
  always_ff @(posedge pclk) begin
    if (rst) begin
      clk_sync_r  <= 2'b11;
      data_sync_r <= 2'b11;
    end else begin
      clk_sync_r  <= {clk_sync_r[0], bus.ps2_clk};
      data_sync_r <= {data_sync_r[0], bus.ps2_data};
    end
  end

  // Run-length filter: the filtered level flips on the FILTER_LEN-th
  // consecutive sample that disagrees with it; any agreeing sample restarts.
  always_comb begin
    filt_flip_s     = 1'b0;
    filt_cnt_next_s = {FILT_W{1'b0}};
    if (clk_sync_r[1] == clk_filt_r) begin
      filt_cnt_next_s = {FILT_W{1'b0}};
    end else if (filt_cnt_r == FILT_LAST) begin
      filt_flip_s     = 1'b1;
      filt_cnt_next_s = {FILT_W{1'b0}};
    end else begin
      filt_cnt_next_s = filt_cnt_r + FILT_W'(1);
    end
  end

  // Filtered clock level, run counter, and the one-cycle fall strobe.
  always_ff @(posedge pclk) begin
    if (rst) begin
      clk_filt_r <= 1'b1;
      filt_cnt_r <= {FILT_W{1'b0}};
      fall_r     <= 1'b0;
    end else begin
      clk_filt_r <= clk_filt_r ^ filt_flip_s;
      filt_cnt_r <= filt_cnt_next_s;
      fall_r     <= filt_flip_s & clk_filt_r;
    end
  end

  // Frame receiver next-state: start, 8 data bits LSB first, parity, stop.
  // The timeout overlay is applied last so that a fall in the same cycle wins.
  always_comb begin
    rx_next_s      = rx_state_r;
    bit_cnt_next_s = bit_cnt_r;
    shift_next_s   = shift_r;
    par_next_s     = par_r;
    tmo_next_s     = {TMO_W{1'b0}};
    accept_s       = 1'b0;
    err_s          = 1'b0;
    case (rx_state_r)
      RX_IDLE: begin
        if (fall_r && !data_s) begin
          rx_next_s      = RX_DATA;
          bit_cnt_next_s = 3'd0;
        end else begin
          rx_next_s = RX_IDLE;
        end
      end
      RX_DATA: begin
        if (fall_r) begin
          shift_next_s = {data_s, shift_r[7:1]};
          if (bit_cnt_r == 3'd7) begin
            rx_next_s = RX_PARITY;
          end else begin
            bit_cnt_next_s = bit_cnt_r + 3'd1;
          end
        end else begin
          rx_next_s = RX_DATA;
        end
      end
      RX_PARITY: begin
        if (fall_r) begin
          par_next_s = data_s;
          rx_next_s  = RX_STOP;
        end else begin
          rx_next_s = RX_PARITY;
        end
      end
      RX_STOP: begin
        if (fall_r) begin
          rx_next_s = RX_IDLE;
          if (data_s && odd_parity_ok(shift_r, par_r)) begin
            accept_s = 1'b1;
          end else begin
            err_s = 1'b1;
          end
        end else begin
          rx_next_s = RX_STOP;
        end
      end
      default: begin
        rx_next_s = RX_IDLE;
      end
    endcase

    if (rx_state_r == RX_IDLE) begin
      tmo_next_s = {TMO_W{1'b0}};
    end else if (fall_r) begin
      tmo_next_s = {TMO_W{1'b0}};
    end else if (tmo_cnt_r == TMO_LAST) begin
      tmo_next_s = {TMO_W{1'b0}};
      rx_next_s  = RX_IDLE;
      err_s      = 1'b1;
    end else begin
      tmo_next_s = tmo_cnt_r + TMO_W'(1);
    end
  end

  // Frame receiver state and datapath registers.
  always_ff @(posedge pclk) begin
    if (rst) begin
      rx_state_r <= RX_IDLE;
      bit_cnt_r  <= 3'd0;
      shift_r    <= 8'h00;
      par_r      <= 1'b0;
      tmo_cnt_r  <= {TMO_W{1'b0}};
    end else begin
      rx_state_r <= rx_next_s;
      bit_cnt_r  <= bit_cnt_next_s;
      shift_r    <= shift_next_s;
      par_r      <= par_next_s;
      tmo_cnt_r  <= tmo_next_s;
    end
  end

  // Scan-code decoder: tracks E0/F0 prefixes and updates the key mask on
  // the accepted byte itself, so key moves together with byte_valid.
  always_comb begin
    sc_next_s  = sc_state_r;
    key_next_s = key_r;
    if (accept_s) begin
      if (is_clear_code(shift_r)) begin
        key_next_s = 4'b0000;
        sc_next_s  = SC_IDLE;
      end else begin
        case (sc_state_r)
          SC_IDLE: begin
            if (shift_r == CODE_EXT) begin
              sc_next_s = SC_EXT;
            end else if (shift_r == CODE_BRK) begin
              sc_next_s = SC_BRK;
            end else begin
              sc_next_s = SC_IDLE;
            end
          end
          SC_EXT: begin
            if (shift_r == CODE_BRK) begin
              sc_next_s = SC_EXT_BRK;
            end else begin
              key_next_s = key_r | arrow_mask(shift_r);
              sc_next_s  = SC_IDLE;
            end
          end
          SC_EXT_BRK: begin
            key_next_s = key_r & ~arrow_mask(shift_r);
            sc_next_s  = SC_IDLE;
          end
          SC_BRK: begin
            sc_next_s = SC_IDLE;
          end
          default: begin
            sc_next_s = SC_IDLE;
          end
        endcase
      end
    end else if (err_s) begin
      // A broken frame drops any pending prefix but keeps the held keys.
      sc_next_s = SC_IDLE;
    end else begin
      sc_next_s = sc_state_r;
    end
  end

  // Scan-code state plus the registered outputs.
  always_ff @(posedge pclk) begin
    if (rst) begin
      sc_state_r   <= SC_IDLE;
      key_r        <= 4'b0000;
      byte_valid_r <= 1'b0;
      frame_err_r  <= 1'b0;
      rx_byte_r    <= 8'h00;
    end else begin
      sc_state_r   <= sc_next_s;
      key_r        <= key_next_s;
      byte_valid_r <= accept_s;
      frame_err_r  <= err_s;
      rx_byte_r    <= accept_s ? shift_r : rx_byte_r;
    end
  end

  assign bus.key        = key_r;
  assign bus.byte_valid = byte_valid_r;
  assign bus.rx_byte    = rx_byte_r;
  assign bus.frame_err  = frame_err_r;

endmodule

// File: tb/tb_ps2_arrow_decoder.sv
// tb_ps2_arrow_decoder
//   Drives PS/2 frames into ps2_arrow_decoder and checks every cycle against
//   an event-level model: each driven frame predicts one pulse (accept or
//   error) and the key mask that must appear with it.
module tb_ps2_arrow_decoder;
  localparam int FL   = 4;
  localparam int TMO  = 300;
  localparam int HALF = 10;

  typedef struct {
    bit         is_err;
    logic [7:0] b;
    logic [3:0] key;
  } ev_t;

  logic pclk = 1'b0;
  logic rst  = 1'b1;

  ps2_arrow_decoder_if bus();

  ps2_arrow_decoder #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TMO)) dut (
    .pclk(pclk),
    .rst (rst),
    .bus (bus)
  );

  always #5 pclk = ~pclk;

  int n_cmp   = 0;
  int n_fail  = 0;
  int n_valid = 0;
  ev_t exp_q[$];

  logic [3:0] key_m   = 4'h0;
  bit         pre_e0  = 1'b0;
  bit         pre_f0  = 1'b0;
  logic [3:0] cur_key = 4'h0;
  logic [7:0] last_b  = 8'h00;
  logic [7:0] arrows [4] = '{8'h75, 8'h72, 8'h6B, 8'h74};
  logic [7:0] clears [4] = '{8'hAA, 8'hFC, 8'h00, 8'hFF};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic logic [3:0] arrow_bit(input logic [7:0] b);
    for (int i = 0; i < 4; i++) if (arrows[i] == b) return 4'(1 << i);
    return 4'h0;
  endfunction

  function automatic bit is_clear(input logic [7:0] b);
    for (int i = 0; i < 4; i++) if (clears[i] == b) return 1'b1;
    return 1'b0;
  endfunction

  // Apply one frame to the model and queue the pulse it must produce.
  task automatic model_apply(input logic [7:0] b, input bit bad);
    ev_t e;
    if (bad) begin
      pre_e0 = 1'b0;
      pre_f0 = 1'b0;
    end else if (is_clear(b)) begin
      key_m = 4'h0; pre_e0 = 1'b0; pre_f0 = 1'b0;
    end else if (pre_f0) begin
      if (pre_e0) key_m = key_m & ~arrow_bit(b);
      pre_e0 = 1'b0; pre_f0 = 1'b0;
    end else if (pre_e0) begin
      if (b == 8'hF0) pre_f0 = 1'b1;
      else begin key_m = key_m | arrow_bit(b); pre_e0 = 1'b0; end
    end else begin
      if (b == 8'hE0) pre_e0 = 1'b1;
      else if (b == 8'hF0) pre_f0 = 1'b1;
    end
    e.is_err = bad;
    e.b      = b;
    e.key    = key_m;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge pclk); #1; end
  endtask

  // One PS/2 bit: data set while clock high, then a low half period.
  // With glitch set, the clock dips for FL-1 cycles during the high phase.
  task automatic clk_bit(input logic d, input bit glitch);
    bus.ps2_data = d;
    if (glitch) begin
      tick(2);
      bus.ps2_clk = 1'b0;
      tick(FL - 1);
      bus.ps2_clk = 1'b1;
      tick(HALF - 2 - (FL - 1));
    end else begin
      tick(HALF);
    end
    bus.ps2_clk = 1'b0;
    tick(HALF);
    bus.ps2_clk = 1'b1;
  endtask

  // Full frame; g selects a glitched bit (0 start, 1..8 data, 9 parity, -1 none).
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input int g);
    logic par;
    par = ~(^b) ^ bad_par;
    model_apply(b, bad_par | bad_stop);
    clk_bit(1'b0, g == 0);
    for (int i = 0; i < 8; i++) clk_bit(b[i], g == i + 1);
    clk_bit(par, g == 9);
    bus.ps2_data = ~bad_stop;
    tick(HALF);
    bus.ps2_clk = 1'b0;
    tick(FL + 4);
    chk("stop_to_pulse_latency", exp_q.size(), 0);
    tick(HALF - FL - 4);
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    tick(2 * HALF);
  endtask

  task automatic send_partial(input logic [7:0] b, input int nbits);
    clk_bit(1'b0, 1'b0);
    for (int i = 0; i < nbits; i++) clk_bit(b[i], 1'b0);
    bus.ps2_data = 1'b1;
  endtask

  task automatic send_ok(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b0, -1);
  endtask

  // Per-cycle compare against the model's predicted pulses and key mask.
  initial begin
    ev_t e;
    forever begin
      @(negedge pclk);
      if (rst) begin
        exp_q.delete();
        cur_key = 4'h0;
        last_b  = 8'h00;
      end else if (bus.byte_valid || bus.frame_err) begin
        chk("single_pulse_kind", bus.byte_valid & bus.frame_err, 1'b0);
        chk("pulse_was_predicted", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("pulse_is_err", bus.frame_err, e.is_err);
          if (!e.is_err) begin
            chk("rx_byte", bus.rx_byte, e.b);
            last_b = e.b;
          end else begin
            chk("rx_byte_held_on_err", bus.rx_byte, last_b);
          end
          chk("key_on_pulse", bus.key, e.key);
          cur_key = e.key;
        end
        if (bus.byte_valid) n_valid++;
      end else begin
        chk("key_between_pulses", bus.key, cur_key);
        chk("rx_byte_hold", bus.rx_byte, last_b);
      end
    end
  end

  initial begin
    int v0;
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    rst = 1'b1;
    tick(5);
    chk("reset_key", bus.key, 4'h0);
    chk("reset_byte_valid", bus.byte_valid, 1'b0);
    chk("reset_frame_err", bus.frame_err, 1'b0);
    chk("reset_rx_byte", bus.rx_byte, 8'h00);
    rst = 1'b0;
    tick(5);

    // Make/break of up.
    v0 = n_valid;
    send_ok(8'hE0); send_ok(8'h75);
    chk("make_up_key", bus.key, 4'b0001);
    chk("make_up_model", key_m, 4'b0001);
    chk("make_up_valid_count", n_valid - v0, 2);
    v0 = n_valid;
    send_ok(8'hE0); send_ok(8'hF0); send_ok(8'h75);
    chk("break_up_key", bus.key, 4'b0000);
    chk("break_up_valid_count", n_valid - v0, 3);

    // Diagonal up+right, then release up.
    send_ok(8'hE0); send_ok(8'h75); send_ok(8'hE0); send_ok(8'h74);
    chk("diag_key", bus.key, 4'b1001);
    chk("diag_model", key_m, 4'b1001);
    send_ok(8'hE0); send_ok(8'hF0); send_ok(8'h75);
    chk("diag_release_key", bus.key, 4'b1000);

    // Clear right, then non-extended keypad codes must not touch key.
    send_ok(8'hE0); send_ok(8'hF0); send_ok(8'h74);
    send_ok(8'h75); send_ok(8'hF0); send_ok(8'h75);
    chk("keypad_key", bus.key, 4'b0000);

    // Bad parity after E0 drops the prefix.
    send_ok(8'hE0);
    send_frame(8'h75, 1'b1, 1'b0, -1);
    send_ok(8'h75);
    chk("parity_err_key", bus.key, 4'b0000);

    // Timeout mid-frame keeps key and drops the prefix.
    send_ok(8'hE0); send_ok(8'h72);
    send_ok(8'hE0);
    send_partial(8'h75, 4);
    model_apply(8'h00, 1'b1);
    tick(TMO - 20);
    chk("timeout_not_early", exp_q.size(), 1);
    tick(40);
    chk("timeout_fired", exp_q.size(), 0);
    send_ok(8'h75);
    chk("timeout_key", bus.key, 4'b0010);

    // Overrun clears everything.
    send_ok(8'hE0); send_ok(8'h6B);
    chk("pre_overrun_key", bus.key, 4'b0110);
    send_ok(8'hFF);
    chk("overrun_key", bus.key, 4'b0000);

    // Short clock glitch inside a frame shifts nothing.
    send_ok(8'hE0);
    send_frame(8'h74, 1'b0, 1'b0, 4);
    chk("glitch_key", bus.key, 4'b1000);

    // Reset in the middle of a frame with a pending prefix.
    send_ok(8'hE0);
    send_partial(8'h75, 3);
    tick(2);
    rst = 1'b1;
    tick(3);
    key_m = 4'h0; pre_e0 = 1'b0; pre_f0 = 1'b0;
    rst = 1'b0;
    tick(3);
    chk("midrst_key", bus.key, 4'b0000);
    chk("midrst_no_err", bus.frame_err, 1'b0);
    v0 = n_valid;
    send_ok(8'h1C);
    chk("post_rst_rx_byte", bus.rx_byte, 8'h1C);
    chk("post_rst_valid_count", n_valid - v0, 1);

    // Randomized traffic.
    for (int n = 0; n < 60; n++) begin
      logic [7:0] b;
      int r, q, g;
      r = int'($urandom_range(0, 99));
      if (r < 30)      b = 8'hE0;
      else if (r < 45) b = 8'hF0;
      else if (r < 75) b = arrows[$urandom_range(0, 3)];
      else if (r < 80) b = clears[$urandom_range(0, 3)];
      else             b = 8'($urandom);
      q = int'($urandom_range(0, 19));
      g = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 9)) : -1;
      send_frame(b, q == 0, q == 1, g);
    end
    chk("final_key_model", bus.key, key_m);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
